// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the Gray-code sequence controller.
// Optional feature macro used by this slice: GRAY_SEQ_PAUSE_EN.
package gray_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Widest counter supported; narrower callers zero-extend and truncate.
    localparam int GRAY_MAX_W = 8;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1'b1);
    endfunction

endpackage

// File: rtl/gray_step_counter.sv
// Loadable up/down binary counter with enable; exposes a registered Gray encoding.
module gray_step_counter
    import gray_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] gray_out
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;

    // Next binary value (load wins over stepping) and its Gray code.
    always_comb begin
        bin_d = bin_q;
        if (load) begin
            bin_d = load_val;
        end else if (en) begin
            if (dir) begin
                bin_d = bin_q - WIDTH'(1'b1);
            end else begin
                bin_d = bin_q + WIDTH'(1'b1);
            end
        end else begin
            bin_d = bin_q;
        end
        gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(bin_d)));
    end

    // Counter and Gray output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign gray_out = gray_q;

endmodule

// File: rtl/gray_seq_ctrl.sv
// Command-driven Gray-code sequencer: IDLE/RUN/DONE FSM plus step counter.
// Define GRAY_SEQ_PAUSE_EN to add the pause input that freezes stepping in RUN.
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_len,
    input  logic             cmd_dir,
`ifdef GRAY_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic [WIDTH-1:0] gray_out,
    output logic             busy,
    output logic             done
);

    // rem is one bit wider so a zero length can stand for a full 2^WIDTH lap.
    localparam logic [WIDTH:0] REM_FULL = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] REM_ONE  = (WIDTH + 1)'(1'b1);

    state_e         state_q;
    state_e         state_d;
    logic [WIDTH:0] rem_q;
    logic [WIDTH:0] rem_d;
    logic           dir_q;
    logic           dir_d;
    logic           busy_q;
    logic           busy_d;
    logic           done_q;
    logic           done_d;
    logic           ready_q;
    logic           ready_d;
    logic           load_s;
    logic           step_s;
    logic           run_en_s;

`ifdef GRAY_SEQ_PAUSE_EN
    assign run_en_s = !pause;
`else
    assign run_en_s = 1'b1;
`endif

    // Next-state, remaining-step and output decode.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        load_s  = 1'b0;
        step_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    load_s  = 1'b1;
                    dir_d   = cmd_dir;
                    rem_d   = (cmd_len == '0) ? REM_FULL : {1'b0, cmd_len};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (run_en_s) begin
                    step_s = 1'b1;
                    rem_d  = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // FSM state and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    gray_step_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load_s),
        .load_val (cmd_start),
        .en       (step_s),
        .dir      (dir_q),
        .gray_out (gray_out)
    );

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench for gray_seq_ctrl (WIDTH=4): queue-based reference model plus directed literal checks.
module tb_gray_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_start = 4'd0;
    logic [3:0] cmd_len = 4'd0;
    logic       cmd_dir = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] gray_out;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    gray_seq_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_len   (cmd_len),
        .cmd_dir   (cmd_dir),
`ifdef GRAY_SEQ_PAUSE_EN
        .pause     (pause),
`endif
        .gray_out  (gray_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] gray_of(input int b);
        logic [3:0] v;
        v = b[3:0];
        return v ^ (v >> 1);
    endfunction

    // Reference model: phase 0 idle, 1 running through a queue of codes, 2 done pulse.
    int         m_phase = 0;
    logic [3:0] m_gray = 4'd0;
    logic [3:0] code_q[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0;
            m_gray  = 4'd0;
            code_q.delete();
        end else begin
            case (m_phase)
                0: if (cmd_valid) begin
                    int n;
                    n = (cmd_len == 4'd0) ? 16 : int'(cmd_len);
                    for (int i = 1; i <= n; i++)
                        code_q.push_back(gray_of(int'(cmd_start) + (cmd_dir ? -i : i)));
                    m_gray  = gray_of(int'(cmd_start));
                    m_phase = 1;
                end
                1: if (!pause) begin
                    m_gray = code_q.pop_front();
                    if (code_q.size() == 0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        chk("m_gray", 8'(gray_out), 8'(m_gray));
        chk("m_busy", 8'(busy), 8'(m_phase != 0));
        chk("m_done", 8'(done), 8'(m_phase == 2));
        chk("m_ready", 8'(cmd_ready), 8'(m_phase == 0));
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    // Offer a command; returns at the sample point of cycle T+1.
    task automatic send(input logic [3:0] s, input logic [3:0] l, input logic d, input bit hold);
        cmd_valid = 1'b1;
        cmd_start = s;
        cmd_len   = l;
        cmd_dir   = d;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            cmd_start = ~s;
            cmd_len   = 4'd9;
            cmd_dir   = ~d;
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic reset_now_check(input string tag);
        #2 reset_n = 1'b0;
        #1;
        chk({tag, "_gray"}, 8'(gray_out), 8'h00);
        chk({tag, "_busy"}, 8'(busy), 8'h00);
        chk({tag, "_done"}, 8'(done), 8'h00);
        chk({tag, "_ready"}, 8'(cmd_ready), 8'h01);
    endtask

    initial begin
        logic [3:0] e030[4] = '{4'h0, 4'h1, 4'h3, 4'h2};
        logic [3:0] e031[3] = '{4'h1, 4'h0, 4'h8};
        int k;

        #1 reset_n = 1'b0;
        repeat (3) cyc();
        chk("rst_gray", 8'(gray_out), 8'h00);
        chk("rst_ready", 8'(cmd_ready), 8'h01);
        reset_n = 1'b1;

        // Up count of 3 steps, accept at the first edge after release.
        send(4'd0, 4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("r030_gray", 8'(gray_out), 8'(e030[i]));
            chk("r030_done", 8'(done), 8'(i == 3));
            chk("r030_busy", 8'(busy), 8'h01);
            if (i < 3) cyc();
        end
        cyc();
        chk("r030_ready", 8'(cmd_ready), 8'h01);
        chk("r030_idle_gray", 8'(gray_out), 8'h02);

        // Down count through the 0 -> 15 wrap.
        send(4'd1, 4'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("r031_gray", 8'(gray_out), 8'(e031[i]));
            chk("r031_done", 8'(done), 8'(i == 2));
            if (i < 2) cyc();
        end
        cyc();

        // Full lap: zero length means 16 steps.
        send(4'd5, 4'd0, 1'b0, 1'b0);
        k = 1;
        while (done !== 1'b1 && k < 40) begin
            cyc();
            k++;
        end
        chk("r032_done_cycle", 8'(k), 8'd17);
        chk("r032_final", 8'(gray_out), 8'h07);
        cyc();

        // Commands offered while busy are ignored.
        send(4'd0, 4'd3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("r033_gray", 8'(gray_out), 8'(e030[i]));
            chk("r033_ready", 8'(cmd_ready), 8'h00);
            if (i == 3) cmd_valid = 1'b0;
            else cyc();
        end
        cyc();

`ifdef GRAY_SEQ_PAUSE_EN
        send(4'd0, 4'd3, 1'b0, 1'b0);
        cyc();
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("r033p_frozen", 8'(gray_out), 8'h01);
            cyc();
        end
        pause = 1'b0;
        chk("r033p_t5", 8'(gray_out), 8'h01);
        cyc();
        chk("r033p_t6", 8'(gray_out), 8'h03);
        cyc();
        chk("r033p_t7_gray", 8'(gray_out), 8'h02);
        chk("r033p_t7_done", 8'(done), 8'h01);
        cyc();
`endif

        // Asynchronous reset in the middle of a run.
        send(4'd0, 4'd3, 1'b0, 1'b0);
        cyc();
        reset_now_check("r034");
        cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("r034_no_done", 8'(done), 8'h00);
            cyc();
        end
        send(4'd2, 4'd1, 1'b0, 1'b0);
        chk("r034_new_start", 8'(gray_out), 8'h03);
        cyc();
        chk("r034_new_end", 8'(gray_out), 8'h02);
        chk("r034_new_done", 8'(done), 8'h01);
        cyc();

        // Randomized traffic; the model comparison covers every cycle.
        for (int c = 0; c < 1500; c++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_start = 4'($urandom_range(0, 15));
            cmd_len   = 4'($urandom_range(0, 15));
            cmd_dir   = 1'($urandom_range(0, 1));
`ifdef GRAY_SEQ_PAUSE_EN
            pause     = ($urandom_range(0, 4) == 0);
`endif
            if ($urandom_range(0, 199) == 0) begin
                reset_now_check("rnd_rst");
                cyc();
                reset_n = 1'b1;
            end else begin
                cyc();
            end
        end
        cmd_valid = 1'b0;
        pause = 1'b0;
        repeat (20) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
